// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing generator with a clock divider for the pixel rate.
// Counter origin is the start of sync; all outputs are flops aligned with hcount/vcount.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pixel_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_BACK_AT   = 10'(H_SYNC);
  localparam logic [9:0] H_ACTIVE_AT = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_FRONT_AT  = 10'(H_SYNC + H_BP + H_ACTIVE);

  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_BACK_AT   = 10'(V_SYNC);
  localparam logic [9:0] V_ACTIVE_AT = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_FRONT_AT  = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} phase_t;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             pe_next;
  logic             line_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  phase_t           h_phase;
  phase_t           h_phase_next;
  phase_t           v_phase;
  phase_t           v_phase_next;

  // Next-state counters and phases; outputs are registered from these so they line up with the counters.
  always_comb begin
    div_next     = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    pe_next      = (div == DIV_LAST);
    line_wrap    = pixel_en && (hcount == H_LAST);
    h_next       = hcount;
    v_next       = vcount;
    h_phase_next = h_phase;
    v_phase_next = v_phase;

    if (pixel_en) begin
      h_next = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
      case (h_next)
        H_BACK_AT:   h_phase_next = BACK;
        H_ACTIVE_AT: h_phase_next = ACTIVE;
        H_FRONT_AT:  h_phase_next = FRONT;
        10'd0:       h_phase_next = SYNC;
        default:     h_phase_next = h_phase;
      endcase
    end

    if (line_wrap) begin
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      case (v_next)
        V_BACK_AT:   v_phase_next = BACK;
        V_ACTIVE_AT: v_phase_next = ACTIVE;
        V_FRONT_AT:  v_phase_next = FRONT;
        10'd0:       v_phase_next = SYNC;
        default:     v_phase_next = v_phase;
      endcase
    end
  end

  // Reset beats pixel_en; a mid-frame reset restarts the frame at (0,0) on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      pixel_en    <= 1'b0;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      h_phase     <= SYNC;
      v_phase     <= SYNC;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      pixel_en    <= pe_next;
      hcount      <= h_next;
      vcount      <= v_next;
      h_phase     <= h_phase_next;
      v_phase     <= v_phase_next;
      hSync       <= (h_phase_next != SYNC);
      vSync       <= (v_phase_next != SYNC);
      bright      <= (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
      frame_start <= pe_next && (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

endmodule
